// File: rtl/random_cell_gen.sv
// random_cell_gen
//   Picks a random grid-aligned pixel coordinate inside the playfield on
//   request. A free-running 16-bit Galois LFSR supplies candidate column/row
//   indices. Out-of-range candidates are discarded. In-range candidates are
//   offered to the snake-body occupancy logic, and the generator retries
//   until a free cell is found or MAX_TRIES attempts have been used.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   seed_load, seed   reload the LFSR (a zero seed is replaced by DEF_SEED)
//   req               request a new coordinate (only accepted when idle)
//   busy              high while an attempt is in progress (DRAW/CHECK)
//   valid             one-cycle pulse when x/y have been updated
//   fail              qualifies valid: attempts exhausted without a free cell
//   x, y              pixel coordinate (col*CELL, row*CELL), held between pulses
//   occ_col, occ_row  candidate cell presented to the occupancy logic
//   occ_hit           combinational reply from the occupancy logic
module random_cell_gen #(
    parameter int          GRID_W    = 640,
    parameter int          GRID_H    = 480,
    parameter int          CELL      = 10,
    parameter int          CB        = 6,
    parameter int          MAX_TRIES = 16,
    parameter logic [15:0] DEF_SEED  = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          seed_load,
    input  logic [15:0]   seed,
    input  logic          req,
    output logic          busy,
    output logic          valid,
    output logic          fail,
    output logic [9:0]    x,
    output logic [8:0]    y,
    output logic [CB-1:0] occ_col,
    output logic [CB-1:0] occ_row,
    input  logic          occ_hit
);

    localparam logic [CB:0] COLS_L = (CB+1)'(GRID_W / CELL);
    localparam logic [CB:0] ROWS_L = (CB+1)'(GRID_H / CELL);
    localparam logic [7:0]  MAX_T  = 8'(MAX_TRIES);
    localparam logic [9:0]  CELL_X = 10'(CELL);
    localparam logic [8:0]  CELL_Y = 9'(CELL);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CHECK, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_lfsr, w_lfsr_step;
    logic [7:0]    r_tries, w_tries_nxt, w_tries_inc;
    logic [9:0]    r_x, w_x_nxt, w_x_cand;
    logic [8:0]    r_y, w_y_nxt, w_y_cand;
    logic          r_fail, w_fail_nxt;
    logic          r_drawn, w_drawn_nxt;
    logic [CB-1:0] r_occ_col, w_occ_col_nxt;
    logic [CB-1:0] r_occ_row, w_occ_row_nxt;
    logic [CB-1:0] w_col, w_row;
    logic          w_in_range;

    // Galois right shift, taps x^16+x^14+x^13+x^11+1
    assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lfsr <= DEF_SEED;
        else if (seed_load)
            r_lfsr <= (seed == 16'h0000) ? DEF_SEED : seed;
        else
            r_lfsr <= w_lfsr_step;
    end

    assign w_col       = r_lfsr[CB-1:0];
    assign w_row       = r_lfsr[CB+7:8];
    assign w_in_range  = ({1'b0, w_col} < COLS_L) && ({1'b0, w_row} < ROWS_L);
    assign w_tries_inc = r_tries + 8'd1;
    assign w_x_cand    = 10'(r_occ_col) * CELL_X;
    assign w_y_cand    = 9'(r_occ_row) * CELL_Y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tries   <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_fail    <= 1'b0;
            r_drawn   <= 1'b0;
            r_occ_col <= '0;
            r_occ_row <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tries   <= w_tries_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_fail    <= w_fail_nxt;
            r_drawn   <= w_drawn_nxt;
            r_occ_col <= w_occ_col_nxt;
            r_occ_row <= w_occ_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tries_nxt   = r_tries;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_fail_nxt    = r_fail;
        w_drawn_nxt   = r_drawn;
        w_occ_col_nxt = r_occ_col;
        w_occ_row_nxt = r_occ_row;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt = S_DRAW;
                    w_tries_nxt = '0;
                    w_drawn_nxt = 1'b0;
                end
            end
            S_DRAW: begin
                w_tries_nxt = w_tries_inc;
                if (w_in_range) begin
                    w_occ_col_nxt = w_col;
                    w_occ_row_nxt = w_row;
                    w_drawn_nxt   = 1'b1;
                    w_state_nxt   = S_CHECK;
                end else if (w_tries_inc >= MAX_T) begin
                    // Giving up on a rejected draw: report the last in-range
                    // candidate of this request if there was one, else hold x/y.
                    w_state_nxt = S_DONE;
                    w_fail_nxt  = 1'b1;
                    if (r_drawn) begin
                        w_x_nxt = w_x_cand;
                        w_y_nxt = w_y_cand;
                    end
                end
            end
            S_CHECK: begin
                if (!occ_hit) begin
                    w_x_nxt     = w_x_cand;
                    w_y_nxt     = w_y_cand;
                    w_fail_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (r_tries < MAX_T) begin
                    w_state_nxt = S_DRAW;
                end else begin
                    w_x_nxt     = w_x_cand;
                    w_y_nxt     = w_y_cand;
                    w_fail_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state == S_DRAW) || (r_state == S_CHECK);
    assign valid   = (r_state == S_DONE);
    assign fail    = valid & r_fail;
    assign x       = r_x;
    assign y       = r_y;
    assign occ_col = r_occ_col;
    assign occ_row = r_occ_row;

endmodule

// File: tb/tb_random_cell_gen.sv
// tb_random_cell_gen
//   Self-checking bench for random_cell_gen at default parameters. Every
//   request is paired with seed_load so the starting LFSR value is known; a
//   reference model walks the attempt procedure over the LFSR sequence and
//   predicts latency, x/y and fail. Occupancy comes from a random bitmap.
module tb_random_cell_gen;

    localparam int MAXT = 16;

    logic        clk = 1'b0;
    logic        rst, seed_load, req, occ_hit;
    logic [15:0] seed;
    logic        busy, valid, fail;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [5:0]  occ_col, occ_row;

    bit          occ_map [0:4095];
    bit          force_hit;
    int          n_tests, n_fail;
    int          mx, my;
    int          got_lat;
    logic [5:0]  chk_col, chk_row;

    random_cell_gen #(
        .GRID_W(640), .GRID_H(480), .CELL(10), .CB(6),
        .MAX_TRIES(MAXT), .DEF_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
        .busy(busy), .valid(valid), .fail(fail), .x(x), .y(y),
        .occ_col(occ_col), .occ_row(occ_row), .occ_hit(occ_hit)
    );

    always #5 clk = ~clk;

    always_comb occ_hit = force_hit | occ_map[{occ_row, occ_col}];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Attempt procedure over the LFSR sequence; cycle 1 is the first DRAW.
    task automatic model_op(input logic [15:0] s, output int ef, output int lat);
        logic [15:0] v;
        int t, tries, c, r, lc, lr;
        bit have;
        v = (s == 16'h0) ? 16'hACE1 : s;
        t = 1; tries = 0; have = 0; lc = 0; lr = 0; ef = 0; lat = 0;
        for (int k = 0; k < 2 * MAXT; k++) begin
            tries++;
            c = int'(v[5:0]);
            r = int'(v[13:8]);
            if (c >= 64 || r >= 48) begin
                v = lfsr_next(v);
                if (tries >= MAXT) begin
                    ef = 1; lat = t + 1;
                    if (have) begin mx = lc * 10; my = lr * 10; end
                    return;
                end
                t = t + 1;
            end else begin
                have = 1; lc = c; lr = r;
                v = lfsr_next(lfsr_next(v));
                if (!(force_hit || occ_map[r * 64 + c])) begin
                    ef = 0; lat = t + 2; mx = c * 10; my = r * 10;
                    return;
                end
                if (tries >= MAXT) begin
                    ef = 1; lat = t + 2; mx = c * 10; my = r * 10;
                    return;
                end
                t = t + 2;
            end
        end
    endtask

    task automatic run_op(input logic [15:0] s, input string tag);
        int ef, lat, k;
        bit found, busy_ok;
        model_op(s, ef, lat);
        @(negedge clk);
        seed = s; seed_load = 1'b1; req = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; req = 1'b0;
        found = 0; busy_ok = 1; chk_col = '0; chk_row = '0;
        for (k = 1; k <= 60; k++) begin
            if (valid) begin found = 1; break; end
            if (!busy) busy_ok = 0;
            if (k == 2) begin chk_col = occ_col; chk_row = occ_row; end
            @(negedge clk);
        end
        got_lat = found ? k : 0;
        check({tag, "_lat"}, got_lat, lat);
        check({tag, "_busy"}, int'(busy_ok), 1);
        if (found) begin
            check({tag, "_x"}, int'(x), mx);
            check({tag, "_y"}, int'(y), my);
            check({tag, "_fail"}, int'(fail), ef);
            @(negedge clk);
            check({tag, "_pulse"}, int'(valid), 0);
            check({tag, "_idle"}, int'(busy), 0);
        end
    endtask

    initial begin
        int saw, pct;
        logic [15:0] s;
        n_tests = 0; n_fail = 0; mx = 0; my = 0;
        rst = 1'b1; seed_load = 1'b0; req = 1'b0; seed = '0; force_hit = 0;
        foreach (occ_map[i]) occ_map[i] = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_occ", int'({occ_row, occ_col}), 0);
        rst = 1'b0;
        saw = 0;
        repeat (5) begin @(negedge clk); if (valid || busy) saw = 1; end
        check("idle_quiet", saw, 0);

        // minimum latency with a known seed
        run_op(16'h0A05, "seed0a05");
        check("seed0a05_col", int'(chk_col), 5);
        check("seed0a05_row", int'(chk_row), 10);
        check("seed0a05_x50", int'(x), 50);
        check("seed0a05_y100", int'(y), 100);

        // first candidate out of range, no CHECK for it
        run_op(16'h3A05, "seed3a05");
        check("seed3a05_slow", int'(got_lat > 3), 1);
        check("seed3a05_rng", int'(x < 640 && y < 480), 1);

        // always occupied: must give up within the worst-case bound
        force_hit = 1;
        run_op(16'h1234, "allhit");
        check("allhit_fail", int'(fail === 1'b0 && got_lat == 0 ? 0 : 1), 1);
        check("allhit_bound", int'(got_lat >= 1 && got_lat <= 34), 1);
        check("allhit_grid", int'((x % 10 == 0) && (y % 10 == 0) && x < 640 && y < 480), 1);
        force_hit = 0;

        // zero seed behaves as the default seed
        run_op(16'h0000, "seedzero");
        run_op(16'hACE1, "seedace1");

        // reset during CHECK
        @(negedge clk);
        seed = 16'h0A05; seed_load = 1'b1; req = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; req = 1'b0;
        @(negedge clk);
        check("midrst_incheck", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_x", int'(x), 0);
        check("midrst_y", int'(y), 0);
        mx = 0; my = 0;
        saw = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin @(negedge clk); if (valid) saw = 1; end
        check("midrst_novalid", saw, 0);
        run_op(16'h0A05, "afterrst");

        // randomized requests against the model
        for (int n = 0; n < 40; n++) begin
            pct = ($urandom_range(0, 3) == 0) ? 97 : int'($urandom_range(0, 60));
            foreach (occ_map[i]) occ_map[i] = ($urandom_range(0, 99) < pct);
            force_hit = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(s, $sformatf("rnd%0d", n));
        end
        force_hit = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
